// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding imem handshake, IF/ID register,
// one-entry skid buffer, stall and redirect handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        FetchWrite,
   input  logic        PCSrc,
   input  logic [31:0] pc_branch,
   input  logic        IF_Flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        inst_valid
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [XLEN-1:0]   next_pc;
   logic [XLEN-1:0]   next_pc_n;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_addr_n;
   logic              skid_valid;
   logic              skid_valid_n;
   logic [XLEN-1:0]   skid_inst;
   logic [XLEN-1:0]   skid_pc;
   logic              accept;
   logic              can_issue;
   logic              issue;

   assign imem_addr = req_addr;

   // Response is usable only when live and not being redirected away
   always_comb begin
      accept = imem_ack && (state == BUSY) && !PCSrc;
   end

   // Skid occupancy at the end of this cycle; gates new issues
   always_comb begin
      skid_valid_n = skid_valid;
      if (IF_Flush) begin
         skid_valid_n = 1'b0;
      end else if (!FetchWrite) begin
         if (accept) begin
            skid_valid_n = 1'b1;
         end
      end else begin
         skid_valid_n = 1'b0;
      end
      can_issue = PCWrite && !PCSrc && !skid_valid_n;
   end

   // Request FSM next-state and issue decision
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      case (state)
         IDLE: begin
            if (can_issue) begin
               state_n = BUSY;
               issue   = 1'b1;
            end
         end
         BUSY: begin
            if (PCSrc) begin
               state_n = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               if (can_issue) begin
                  issue = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DROP: begin
            if (imem_ack) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Address update; a redirect overrides the sequential increment
   always_comb begin
      next_pc_n  = next_pc;
      req_addr_n = req_addr;
      if (issue) begin
         req_addr_n = next_pc;
         next_pc_n  = next_pc + XLEN'(4);
      end
      if (PCSrc) begin
         next_pc_n = pc_branch;
      end
   end

   // FSM state, request flag and address registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         imem_req <= 1'b0;
         next_pc  <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_n;
         imem_req <= (state_n != IDLE);
         next_pc  <= next_pc_n;
         req_addr <= req_addr_n;
      end
   end

   // Skid buffer catches a response that arrives while IF/ID is held
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_inst  <= NOP;
         skid_pc    <= '0;
      end else begin
         skid_valid <= skid_valid_n;
         if (accept && !FetchWrite && !IF_Flush) begin
            skid_inst <= imem_rdata;
            skid_pc   <= req_addr;
         end
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         instruction <= NOP;
         pc          <= '0;
         inst_valid  <= 1'b0;
      end else if (IF_Flush) begin
         instruction <= NOP;
         inst_valid  <= 1'b0;
      end else if (!FetchWrite) begin
         instruction <= instruction;
      end else if (skid_valid) begin
         instruction <= skid_inst;
         pc          <= skid_pc;
         inst_valid  <= 1'b1;
      end else if (accept) begin
         instruction <= imem_rdata;
         pc          <= req_addr;
         inst_valid  <= 1'b1;
      end else begin
         instruction <= NOP;
         inst_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: hand-derived vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, PCWrite, FetchWrite, PCSrc, IF_Flush, imem_ack;
   logic [31:0] pc_branch, imem_rdata;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, instruction, pc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .FetchWrite(FetchWrite),
      .PCSrc(PCSrc), .pc_branch(pc_branch), .IF_Flush(IF_Flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
      .inst_valid(inst_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, pw, fw, src, flush, ack;
      logic [31:0] pb;
      logic        exp_req;
      logic [31:0] exp_addr, exp_inst, exp_pc;
      logic        exp_valid, chk_pc;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, input logic src, input logic [31:0] pb,
                               input logic ack, input logic ereq, input logic [31:0] eaddr,
                               input logic [31:0] einst, input logic [31:0] epc,
                               input logic ev, input logic cpc);
      vec_t v;
      v.rst = r; v.pw = 1'b1; v.fw = 1'b1; v.src = src; v.flush = 1'b0; v.ack = ack;
      v.pb = pb; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_inst = einst;
      v.exp_pc = epc; v.exp_valid = ev; v.chk_pc = cpc;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
   entry_t      held_q [$];
   bit          m_out, m_drop, m_valid;
   logic [31:0] m_addr, m_nxt, m_inst, m_pc;
   int          mem_cnt = 0, mem_wait = 0, wait_lo = 0, wait_hi = 0;
   logic [31:0] key = 32'h0;

   task automatic model_reset();
      m_out = 0; m_drop = 0; m_valid = 0;
      m_addr = RESET_PC; m_nxt = RESET_PC; m_inst = NOP; m_pc = 32'h0;
      held_q.delete();
   endtask

   // One clock: memory responds to the DUT's current request, model advances, compare
   task automatic step(input bit r, input bit pw, input bit fw, input bit src,
                       input bit fl, input logic [31:0] pb);
      bit          ack, got, retired, may_issue, req_before;
      logic [31:0] data;
      entry_t      e;
      req_before = imem_req;
      ack = 1'b0;
      if (imem_req) begin
         if (mem_cnt == 0) mem_wait = $urandom_range(wait_hi, wait_lo);
         ack = (mem_cnt >= mem_wait);
      end
      rst = r; PCWrite = pw; FetchWrite = fw; PCSrc = src; IF_Flush = fl; pc_branch = pb;
      imem_ack = ack;
      imem_rdata = ack ? (imem_addr ^ key) : 32'hDEAD_BEEF;

      if (r) begin
         model_reset();
      end else begin
         retired = m_out && ack;
         got     = retired && !m_drop && !src;
         data    = m_addr ^ key;
         if (fl) begin
            m_inst = NOP; m_valid = 0; held_q.delete();
         end else if (!fw) begin
            if (got) held_q.push_back('{data, m_addr});
         end else if (held_q.size() > 0) begin
            e = held_q.pop_front();
            m_inst = e.inst; m_pc = e.pc; m_valid = 1;
         end else if (got) begin
            m_inst = data; m_pc = m_addr; m_valid = 1;
         end else begin
            m_inst = NOP; m_valid = 0;
         end
         may_issue = pw && !src && (held_q.size() == 0) && (!m_out || (retired && !m_drop));
         if (retired) begin
            m_out = 0; m_drop = 0;
         end else if (src && m_out) begin
            m_drop = 1;
         end
         if (may_issue) begin
            m_out = 1; m_drop = 0; m_addr = m_nxt; m_nxt = m_nxt + 32'd4;
         end
         if (src) m_nxt = pb;
      end

      @(posedge clk); #1;
      if (r || ack) mem_cnt = 0;
      else if (req_before) mem_cnt++;

      chk("model_req", 32'(imem_req), 32'(m_out));
      if (m_out) chk("model_addr", imem_addr, m_addr);
      chk("model_valid", 32'(inst_valid), 32'(m_valid));
      chk("model_inst", instruction, m_inst);
      if (m_valid) chk("model_pc", pc, m_pc);
   endtask

   task automatic nstep();
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic rstep();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      bit          saw20, found;
      logic [31:0] addrs [3];
      int          na;

      rst = 1'b1; PCWrite = 1'b1; FetchWrite = 1'b1; PCSrc = 1'b0; IF_Flush = 1'b0;
      pc_branch = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

      // zero-wait startup, redirect on an ack, reset while busy (data = address)
      vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   NOP,     32'h0,   0, 1);
      vecs[1]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   NOP,     32'h0,   0, 0);
      vecs[2]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   32'h0,   32'h0,   1, 1);
      vecs[3]  = mk(0, 0, 32'h0,   1, 1, 32'h8,   32'h4,   32'h4,   1, 1);
      vecs[4]  = mk(0, 1, 32'h100, 1, 0, 32'h0,   NOP,     32'h0,   0, 0);
      vecs[5]  = mk(0, 0, 32'h0,   0, 1, 32'h100, NOP,     32'h0,   0, 0);
      vecs[6]  = mk(0, 0, 32'h0,   1, 1, 32'h104, 32'h100, 32'h100, 1, 1);
      vecs[7]  = mk(0, 0, 32'h0,   0, 1, 32'h104, NOP,     32'h0,   0, 0);
      vecs[8]  = mk(0, 0, 32'h0,   1, 1, 32'h108, 32'h104, 32'h104, 1, 1);
      vecs[9]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   NOP,     32'h0,   0, 1);
      vecs[10] = mk(0, 0, 32'h0,   0, 1, 32'h0,   NOP,     32'h0,   0, 0);

      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst; PCWrite = vecs[i].pw; FetchWrite = vecs[i].fw;
         PCSrc = vecs[i].src; IF_Flush = vecs[i].flush; pc_branch = vecs[i].pb;
         imem_ack = vecs[i].ack; imem_rdata = imem_addr;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_inst", i), instruction, vecs[i].exp_inst);
         chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].chk_pc) chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      end

      // two wait cycles per fetch
      key = 32'h0; wait_lo = 2; wait_hi = 2;
      rstep();
      for (int i = 0; i < 14; i++) nstep();

      // stall across the ack for 0x10, then release
      wait_lo = 0; wait_hi = 0;
      rstep();
      for (int i = 0; i < 5; i++) nstep();
      chk("stall_pre_addr", imem_addr, 32'h10);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_hold_inst", instruction, 32'hC);
      chk("stall_no_req", 32'(imem_req), 32'h0);
      nstep();
      chk("stall_rel_inst", instruction, 32'h10);
      chk("stall_rel_valid", 32'(inst_valid), 32'h1);
      chk("stall_rel_req", 32'(imem_req), 32'h1);
      chk("stall_rel_addr", imem_addr, 32'h14);
      nstep();
      chk("stall_next_inst", instruction, 32'h14);

      // redirect + flush while 0x20 still has 2 cycles to wait
      wait_lo = 3; wait_hi = 3;
      rstep();
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         nstep();
         if (imem_req && imem_addr == 32'h20 && mem_cnt == 0) found = 1;
      end
      chk("drop_reach_20", 32'(found), 32'h1);
      nstep();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
      chk("drop_req_held", 32'(imem_req), 32'h1);
      chk("drop_bubble", 32'(inst_valid), 32'h0);
      saw20 = 0; found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         nstep();
         if (inst_valid && instruction == 32'h20) saw20 = 1;
         if (imem_req && imem_addr != 32'h20) begin
            found = 1;
            chk("drop_next_addr", imem_addr, 32'h100);
         end
      end
      chk("drop_new_req_seen", 32'(found), 32'h1);
      chk("drop_no_leak", 32'(saw20), 32'h0);

      // redirect in the same cycle as the ack for 0x8
      wait_lo = 0; wait_hi = 0;
      rstep();
      for (int i = 0; i < 3; i++) nstep();
      chk("ackredir_pre_addr", imem_addr, 32'h8);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
      chk("ackredir_req", 32'(imem_req), 32'h0);
      chk("ackredir_bubble", instruction, NOP);
      nstep();
      chk("ackredir_addr", imem_addr, 32'h100);
      nstep();
      chk("ackredir_inst", instruction, 32'h100);

      // reset while a waited request is outstanding
      wait_lo = 2; wait_hi = 2;
      rstep(); nstep(); nstep();
      rstep();
      chk("rstbusy_req", 32'(imem_req), 32'h0);
      chk("rstbusy_inst", instruction, NOP);
      chk("rstbusy_pc", pc, 32'h0);
      nstep();
      chk("rstbusy_refetch", imem_addr, RESET_PC);

      // address wrap at the top of the space
      wait_lo = 0; wait_hi = 0;
      rstep();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8);
      na = 0;
      for (int i = 0; i < 6 && na < 3; i++) begin
         nstep();
         if (imem_req) begin addrs[na] = imem_addr; na++; end
      end
      chk("wrap_count", 32'(na), 32'd3);
      chk("wrap_a0", addrs[0], 32'hFFFF_FFF8);
      chk("wrap_a1", addrs[1], 32'hFFFF_FFFC);
      chk("wrap_a2", addrs[2], 32'h0);

      // randomized traffic
      key = 32'h5A5A_0000; wait_lo = 0; wait_hi = 3;
      rstep();
      for (int i = 0; i < 1500; i++) begin
         bit r, pw, fw, src, fl;
         r   = ($urandom_range(199, 0) == 0);
         pw  = ($urandom_range(9, 0) != 0);
         fw  = ($urandom_range(6, 0) != 0);
         src = ($urandom_range(11, 0) == 0);
         fl  = src ? bit'($urandom_range(1, 0)) : ($urandom_range(19, 0) == 0);
         step(r, pw, fw, src, fl, $urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
